// File: rtl/ctrl_pipe_dec_if.sv
// ID-stage decode inputs and the per-stage control bundle of ctrl_pipe_dec.
// The master drives the ID instruction and the hazard/flush controls; the slave is the decoder.
interface ctrl_pipe_dec_if;
  logic [5:0] opcode_d;
  logic [5:0] funct_d;
  logic       valid_d;
  logic       stall_d;
  logic       flush_e;

  logic       jump_d;
  logic       branch_d;
  logic       jr_d;
  logic       illegal_d;
  logic       stall_md;

  logic       we_reg_e;
  logic [1:0] reg_dst_e;
  logic       alu_src_e;
  logic [1:0] alu_op_e;
  logic       we_dm_e;
  logic [1:0] dm2reg_e;

  logic       we_reg_m;
  logic       we_dm_m;
  logic [1:0] dm2reg_m;

  logic       we_reg_w;
  logic [1:0] dm2reg_w;

  logic       md_busy;
  logic       hilo_we;

  modport master (
    output opcode_d, funct_d, valid_d, stall_d, flush_e,
    input  jump_d, branch_d, jr_d, illegal_d, stall_md,
    input  we_reg_e, reg_dst_e, alu_src_e, alu_op_e, we_dm_e, dm2reg_e,
    input  we_reg_m, we_dm_m, dm2reg_m, we_reg_w, dm2reg_w, md_busy, hilo_we
  );

  modport slave (
    input  opcode_d, funct_d, valid_d, stall_d, flush_e,
    output jump_d, branch_d, jr_d, illegal_d, stall_md,
    output we_reg_e, reg_dst_e, alu_src_e, alu_op_e, we_dm_e, dm2reg_e,
    output we_reg_m, we_dm_m, dm2reg_m, we_reg_w, dm2reg_w, md_busy, hilo_we
  );
endinterface

// File: rtl/ctrl_pipe_dec.sv
// Main control: decodes in ID, carries the bundle through ID/EX (1), EX/MEM (2), MEM/WB (3 cycles).
// Stalls/flushes only bubble ID/EX; MULDIV_EN adds the MULT busy counter and its hazard stall.
module ctrl_pipe_dec #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  ctrl_pipe_dec_if.slave bus
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
`ifdef MULDIV_EN
  localparam logic [5:0] FN_MULT = 6'b011000;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;
`endif

  typedef struct packed {
    logic       we_reg;
    logic [1:0] reg_dst;
    logic       alu_src;
    logic       branch;
    logic       we_dm;
    logic [1:0] dm2reg;
    logic [1:0] alu_op;
    logic       jump;
  } ctrl_t;

  localparam ctrl_t C_R    = 11'b1_01_0_0_0_00_10_0;
  localparam ctrl_t C_LW   = 11'b1_00_1_0_0_01_00_0;
  localparam ctrl_t C_SW   = 11'b0_00_1_0_1_00_00_0;
  localparam ctrl_t C_BEQ  = 11'b0_00_0_1_0_00_01_0;
  localparam ctrl_t C_ADDI = 11'b1_00_1_0_0_00_00_0;
  localparam ctrl_t C_J    = 11'b0_00_0_0_0_00_00_1;
  localparam ctrl_t C_JAL  = 11'b1_10_0_0_0_10_00_1;

  if (MUL_LAT < 2 || (MUL_LAT - 1) >= (1 << CNT_W)) begin : g_cfg_err
    $error("ctrl_pipe_dec: MUL_LAT must be >= 2 and MUL_LAT-1 must fit in CNT_W bits");
  end

  ctrl_t dec;
  ctrl_t ctrl_d;
  logic  known;
  logic  is_jr;
  logic  take;
  logic  bubble_e;
  logic  md_stall;
`ifdef MULDIV_EN
  logic  is_md;
  logic  is_mult;
`endif

  always_comb begin
    dec   = '0;
    known = 1'b1;
    is_jr = 1'b0;
`ifdef MULDIV_EN
    is_md   = 1'b0;
    is_mult = 1'b0;
`endif
    case (bus.opcode_d)
      OP_R: begin
        dec = C_R;
        case (bus.funct_d)
          6'b000000, 6'b000010, 6'b000011,
          6'b100000, 6'b100001, 6'b100010, 6'b100011,
          6'b100100, 6'b100101, 6'b100110, 6'b100111,
          6'b101010, 6'b101011: ;
          FN_JR: begin
            dec.we_reg = 1'b0;
            dec.jump   = 1'b1;
            is_jr      = 1'b1;
          end
`ifdef MULDIV_EN
          FN_MULT: begin
            dec.we_reg = 1'b0;
            is_mult    = 1'b1;
            is_md      = 1'b1;
          end
          FN_MFHI, FN_MFLO: is_md = 1'b1;
`endif
          default: known = 1'b0;
        endcase
      end
      OP_LW:   dec = C_LW;
      OP_SW:   dec = C_SW;
      OP_BEQ:  dec = C_BEQ;
      OP_ADDI: dec = C_ADDI;
      OP_J:    dec = C_J;
      OP_JAL:  dec = C_JAL;
      default: known = 1'b0;
    endcase
  end

  // Unknown encodings and non-valid slots both collapse to the all-zero bubble.
  assign take   = bus.valid_d & known;
  assign ctrl_d = take ? dec : '0;

  assign bus.jump_d    = ctrl_d.jump;
  assign bus.branch_d  = ctrl_d.branch;
  assign bus.jr_d      = take & is_jr;
  assign bus.illegal_d = bus.valid_d & ~known;
  assign bus.stall_md  = md_stall;

  assign bubble_e = bus.flush_e | bus.stall_d | md_stall;

  logic       we_reg_e, alu_src_e, we_dm_e;
  logic [1:0] reg_dst_e, alu_op_e, dm2reg_e;
  logic       we_reg_m, we_dm_m, we_reg_w;
  logic [1:0] dm2reg_m, dm2reg_w;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg_e  <= 1'b0;
      reg_dst_e <= 2'b00;
      alu_src_e <= 1'b0;
      alu_op_e  <= 2'b00;
      we_dm_e   <= 1'b0;
      dm2reg_e  <= 2'b00;
    end else if (bubble_e) begin
      we_reg_e  <= 1'b0;
      reg_dst_e <= 2'b00;
      alu_src_e <= 1'b0;
      alu_op_e  <= 2'b00;
      we_dm_e   <= 1'b0;
      dm2reg_e  <= 2'b00;
    end else begin
      we_reg_e  <= ctrl_d.we_reg;
      reg_dst_e <= ctrl_d.reg_dst;
      alu_src_e <= ctrl_d.alu_src;
      alu_op_e  <= ctrl_d.alu_op;
      we_dm_e   <= ctrl_d.we_dm;
      dm2reg_e  <= ctrl_d.dm2reg;
    end
  end

  // Later stages never hold; only the writeback-relevant fields travel past EX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_reg_m <= 1'b0;
      we_dm_m  <= 1'b0;
      dm2reg_m <= 2'b00;
      we_reg_w <= 1'b0;
      dm2reg_w <= 2'b00;
    end else begin
      we_reg_m <= we_reg_e;
      we_dm_m  <= we_dm_e;
      dm2reg_m <= dm2reg_e;
      we_reg_w <= we_reg_m;
      dm2reg_w <= dm2reg_m;
    end
  end

  assign bus.we_reg_e  = we_reg_e;
  assign bus.reg_dst_e = reg_dst_e;
  assign bus.alu_src_e = alu_src_e;
  assign bus.alu_op_e  = alu_op_e;
  assign bus.we_dm_e   = we_dm_e;
  assign bus.dm2reg_e  = dm2reg_e;
  assign bus.we_reg_m  = we_reg_m;
  assign bus.we_dm_m   = we_dm_m;
  assign bus.dm2reg_m  = dm2reg_m;
  assign bus.we_reg_w  = we_reg_w;
  assign bus.dm2reg_w  = dm2reg_w;

`ifdef MULDIV_EN
  logic             mult_e;
  logic [CNT_W-1:0] md_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mult_e <= 1'b0;
      md_cnt <= '0;
    end else begin
      mult_e <= ~bubble_e & take & is_mult;
      if (md_cnt != '0)
        md_cnt <= md_cnt - CNT_W'(1);
      else if (mult_e)
        md_cnt <= CNT_W'(MUL_LAT - 1);
    end
  end

  // A MULT in EX has not yet loaded the counter, so it blocks HI/LO users too.
  assign md_stall    = take & is_md & ((md_cnt != '0) | mult_e);
  assign bus.md_busy = (md_cnt != '0);
  assign bus.hilo_we = (md_cnt == CNT_W'(1));
`else
  assign md_stall    = 1'b0;
  assign bus.md_busy = 1'b0;
  assign bus.hilo_we = 1'b0;
`endif

endmodule

// File: tb/tb_ctrl_pipe_dec.sv
// Bench for ctrl_pipe_dec: decode vector table, multi-cycle corner sequences, random vs reference model.
module tb_ctrl_pipe_dec;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ctrl_pipe_dec_if bus ();
  ctrl_pipe_dec #(.MUL_LAT(4), .CNT_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic        ill;
    logic        jr;
    logic [10:0] b;   // {we_reg,reg_dst,alu_src,branch,we_dm,dm2reg,alu_op,jump}
  } ref_t;

  function automatic ref_t ref_dec(input logic [5:0] op, input logic [5:0] fn, input logic v);
    ref_t r;
    r = '0;
    if (v) begin
      case (op)
        6'b000000: begin
          if (fn == 6'b001000) begin
            r.b  = 11'b0_01_0_0_0_00_10_1;
            r.jr = 1'b1;
          end else if (fn inside {6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001,
                                  6'b100010, 6'b100011, 6'b100100, 6'b100101, 6'b100110,
                                  6'b100111, 6'b101010, 6'b101011})
            r.b = 11'b1_01_0_0_0_00_10_0;
`ifdef MULDIV_EN
          else if (fn == 6'b011000)
            r.b = 11'b0_01_0_0_0_00_10_0;
          else if (fn inside {6'b010000, 6'b010010})
            r.b = 11'b1_01_0_0_0_00_10_0;
`endif
          else
            r.ill = 1'b1;
        end
        6'b100011: r.b = 11'b1_00_1_0_0_01_00_0;
        6'b101011: r.b = 11'b0_00_1_0_1_00_00_0;
        6'b000100: r.b = 11'b0_00_0_1_0_00_01_0;
        6'b001000: r.b = 11'b1_00_1_0_0_00_00_0;
        6'b000010: r.b = 11'b0_00_0_0_0_00_00_1;
        6'b000011: r.b = 11'b1_10_0_0_0_10_00_1;
        default:   r.ill = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic logic [8:0] ex_of(input logic [10:0] b);
    return {b[10], b[9:8], b[7], b[2:1], b[5], b[4:3]};
  endfunction

  function automatic logic [8:0] act_ex();
    return {bus.we_reg_e, bus.reg_dst_e, bus.alu_src_e, bus.alu_op_e, bus.we_dm_e, bus.dm2reg_e};
  endfunction

  function automatic logic [17:0] act_regs();
    return {act_ex(), bus.we_reg_m, bus.we_dm_m, bus.dm2reg_m, bus.we_reg_w, bus.dm2reg_w,
            bus.md_busy, bus.hilo_we};
  endfunction

  function automatic logic [4:0] act_comb();
    return {bus.jump_d, bus.branch_d, bus.jr_d, bus.illegal_d, bus.stall_md};
  endfunction

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic v,
                       input logic st, input logic fl);
    bus.opcode_d = op;
    bus.funct_d  = fn;
    bus.valid_d  = v;
    bus.stall_d  = st;
    bus.flush_e  = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       v, st, fl;
    logic [4:0] comb;  // {jump,branch,jr,illegal,stall_md}
    logic [8:0] ex;    // {we_reg,reg_dst,alu_src,alu_op,we_dm,dm2reg}
  } vec_t;

  vec_t vecs[$];

  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] JAL  = 6'b000011;

  initial begin
    logic [5:0]  ops [8];
    logic [5:0]  rfn [13];
    logic [10:0] me, mm, mw;
    ref_t        r;
    logic [5:0]  op, fn;
    logic        v, st, fl;

    ops = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010, 6'b000011};
    rfn = '{6'b000000, 6'b000010, 6'b000011, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
            6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b001000};

    vecs.push_back('{"r_add",     6'b000000, 6'b100000, 1, 0, 0, 5'b00000, 9'b1_01_0_10_0_00});
    vecs.push_back('{"lw",        6'b100011, 6'b000000, 1, 0, 0, 5'b00000, 9'b1_00_1_00_0_01});
    vecs.push_back('{"sw",        6'b101011, 6'b000000, 1, 0, 0, 5'b00000, 9'b0_00_1_00_1_00});
    vecs.push_back('{"beq",       6'b000100, 6'b000000, 1, 0, 0, 5'b01000, 9'b0_00_0_01_0_00});
    vecs.push_back('{"addi",      6'b001000, 6'b000000, 1, 0, 0, 5'b00000, 9'b1_00_1_00_0_00});
    vecs.push_back('{"j",         6'b000010, 6'b000000, 1, 0, 0, 5'b10000, 9'b0});
    vecs.push_back('{"jal",       6'b000011, 6'b000000, 1, 0, 0, 5'b10000, 9'b1_10_0_00_0_10});
    vecs.push_back('{"jr",        6'b000000, 6'b001000, 1, 0, 0, 5'b10100, 9'b0_01_0_10_0_00});
    vecs.push_back('{"ill_op",    6'b111111, 6'b000000, 1, 0, 0, 5'b00010, 9'b0});
    vecs.push_back('{"ill_op_v0", 6'b111111, 6'b000000, 0, 0, 0, 5'b00000, 9'b0});
    vecs.push_back('{"lw_v0",     6'b100011, 6'b000000, 0, 0, 0, 5'b00000, 9'b0});
    vecs.push_back('{"lw_stall",  6'b100011, 6'b000000, 1, 1, 0, 5'b00000, 9'b0});
    vecs.push_back('{"beq_stall", 6'b000100, 6'b000000, 1, 1, 0, 5'b01000, 9'b0});
    vecs.push_back('{"jal_flush", 6'b000011, 6'b000000, 1, 0, 1, 5'b10000, 9'b0});
    vecs.push_back('{"jr_fl_st",  6'b000000, 6'b001000, 1, 1, 1, 5'b10100, 9'b0});
    vecs.push_back('{"ill_funct", 6'b000000, 6'b111111, 1, 0, 0, 5'b00010, 9'b0});
`ifdef MULDIV_EN
    vecs.push_back('{"mult",      6'b000000, 6'b011000, 1, 0, 0, 5'b00000, 9'b0_01_0_10_0_00});
`else
    vecs.push_back('{"mult_ill",  6'b000000, 6'b011000, 1, 0, 0, 5'b00010, 9'b0});
`endif

    // Reset state, checked while rst_n is still low.
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #12;
    chk("reset_regs", 32'(act_regs()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].v, vecs[i].st, vecs[i].fl);
      #1;
      chk({vecs[i].name, "_comb"}, 32'(act_comb()), 32'(vecs[i].comb));
      tick();
      chk({vecs[i].name, "_ex"}, 32'(act_ex()), 32'(vecs[i].ex));
    end

    // Load then a one-cycle stall: bubble in EX, held ADDI follows, LW arrives at WB.
    do_reset();
    drive(LW, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(ADDI, 6'd0, 1'b1, 1'b1, 1'b0);
    tick();
    chk("stall_bubble_we_reg_e", 32'(bus.we_reg_e), 32'd0);
    chk("stall_lw_in_m", 32'({bus.we_reg_m, bus.dm2reg_m}), 32'b101);
    drive(ADDI, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("held_addi_ex", 32'(act_ex()), 32'(9'b1_00_1_00_0_00));
    chk("lw_at_w", 32'({bus.we_reg_w, bus.dm2reg_w}), 32'b101);

    // Async reset between edges with LW in MEM and JAL in EX.
    do_reset();
    drive(LW, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(JAL, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("pre_reset_e_m", 32'({bus.we_reg_e, bus.we_reg_m, bus.dm2reg_m}), 32'b1101);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_no_edge", 32'(act_regs()), 32'd0);
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // JAL flushed on entry never writes back; unflushed JAL writes back 3 edges later.
    drive(JAL, 6'd0, 1'b1, 1'b0, 1'b1);
    tick();
    chk("jal_flush_e", 32'({bus.we_reg_e, bus.reg_dst_e}), 32'd0);
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("jal_flush_no_wb", 32'(bus.we_reg_w), 32'd0);
    drive(JAL, 6'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("jal_not_yet_w", 32'(bus.we_reg_w), 32'd0);
    tick();
    chk("jal_wb_lat3", 32'({bus.we_reg_w, bus.dm2reg_w}), 32'b110);

`ifdef MULDIV_EN
    do_reset();
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0);
    tick();
    drive(6'b000000, 6'b010010, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("mflo_stall_md", 32'(bus.stall_md), 32'd1);
      chk("md_busy_seq", 32'(bus.md_busy), 32'(i >= 1));
      chk("hilo_we_seq", 32'(bus.hilo_we), 32'(i == 3));
      tick();
    end
    chk("md_idle", 32'({bus.stall_md, bus.md_busy, bus.hilo_we}), 32'd0);
    tick();
    chk("mflo_enters_ex", 32'(act_ex()), 32'(9'b1_01_0_10_0_00));
`else
    do_reset();
    drive(6'b000000, 6'b011000, 1'b1, 1'b0, 1'b0);
    #1;
    chk("mult_illegal", 32'(bus.illegal_d), 32'd1);
    tick();
    chk("mult_bubble_ex", 32'(act_ex()), 32'd0);
`endif

    // Random traffic against a three-slot history model.
    do_reset();
    me = '0; mm = '0; mw = '0;
    for (int c = 0; c < 400; c++) begin
      int k;
      k  = $urandom_range(0, 8);
      op = (k == 8) ? 6'($urandom) : ops[k];
      fn = ($urandom_range(0, 1) == 0) ? rfn[$urandom_range(0, 12)] : 6'($urandom);
`ifdef MULDIV_EN
      if (fn inside {6'b011000, 6'b010000, 6'b010010}) fn = 6'b100000;
`endif
      v  = ($urandom_range(0, 7) != 0);
      st = ($urandom_range(0, 6) == 0);
      fl = ($urandom_range(0, 8) == 0);
      drive(op, fn, v, st, fl);
      #1;
      r = ref_dec(op, fn, v);
      chk("rand_comb", 32'(act_comb()), 32'({r.b[0], r.b[6], r.jr, r.ill, 1'b0}));
      tick();
      mw = mm;
      mm = me;
      me = (st || fl) ? 11'd0 : r.b;
      chk("rand_regs", 32'(act_regs()),
          32'({ex_of(me), mm[10], mm[5], mm[4:3], mw[10], mw[4:3], 2'b00}));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
